count_monitor: RTL

//   Downstream checker for the 4-bit free-running counter output. Samples the

---
 rtl/count_monitor.sv | 109 ++++++++++
 1 files changed

// File: rtl/count_monitor.sv
// count_monitor: checks a free-running counter stream, locks after LOCK_LEN +1 steps, flags breaks and counts wraps/errors
//   clk, rst (sync, active-high); cnt_in/cnt_vld sampled stream;
//   locked, err, wrap, err_cnt, wrap_cnt, stall status outputs (latency 1).
//   Optional macro COUNT_MON_STALL_EN enables the idle-stall timeout in LOCKED.
module count_monitor #(
  parameter int WIDTH     = 4,
  parameter int LOCK_LEN  = 3,
  parameter int ERR_W     = 8,
  parameter int STALL_MAX = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             cnt_vld,
  output logic             locked,
  output logic             err,
  output logic             wrap,
  output logic [ERR_W-1:0] err_cnt,
  output logic [ERR_W-1:0] wrap_cnt,
  output logic             stall
);
  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;
  localparam int RUN_W = $clog2(LOCK_LEN + 1);
  localparam logic [RUN_W-1:0] LOCK_V = RUN_W'(LOCK_LEN);
  state_t           r_state;
  logic [WIDTH-1:0] r_prev;
  logic [RUN_W-1:0] r_run;
  logic             r_err, r_wrap;
  logic [ERR_W-1:0] r_err_cnt, r_wrap_cnt;
  logic             w_match, w_lock;
  logic [RUN_W-1:0] w_run_nxt;
  assign w_match   = cnt_in == r_prev + 1'b1;
  assign w_run_nxt = r_run + 1'b1;
  assign w_lock    = w_run_nxt == LOCK_V;
`ifdef COUNT_MON_STALL_EN
  localparam int SC_W = $clog2(STALL_MAX + 1);
  localparam logic [SC_W-1:0] STALL_LAST = SC_W'(STALL_MAX - 1);
  logic [SC_W-1:0] r_stall_cnt;
  logic            r_stall;
  assign stall = r_stall;
`else
  logic w_unused_stall;
  assign w_unused_stall = ^32'(STALL_MAX);
  assign stall = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_prev     <= '0;
      r_run      <= '0;
      r_err      <= 1'b0;
      r_wrap     <= 1'b0;
      r_err_cnt  <= '0;
      r_wrap_cnt <= '0;
`ifdef COUNT_MON_STALL_EN
      r_stall     <= 1'b0;
      r_stall_cnt <= '0;
`endif
    end else begin
      r_err  <= 1'b0;
      r_wrap <= 1'b0;
      if (cnt_vld) begin
        r_prev <= cnt_in;
        case (r_state)
          IDLE: begin
            r_run   <= '0;
            r_state <= ACQUIRE;
          end
          ACQUIRE: begin
            r_run <= (w_match && !w_lock) ? w_run_nxt : '0;
            if (w_match && w_lock) r_state <= LOCKED;
          end
          LOCKED: begin
            if (!w_match) begin
              r_err   <= 1'b1;
              r_run   <= '0;
              r_state <= ACQUIRE;
              if (!(&r_err_cnt)) r_err_cnt <= r_err_cnt + 1'b1;
            end else if (&r_prev) begin
              r_wrap     <= 1'b1;
              r_wrap_cnt <= r_wrap_cnt + 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
`ifdef COUNT_MON_STALL_EN
      r_stall <= 1'b0;
      if (!cnt_vld && r_state == LOCKED) begin
        if (r_stall_cnt == STALL_LAST) begin
          r_stall     <= 1'b1;
          r_state     <= IDLE;
          r_run       <= '0;
          r_stall_cnt <= '0;
        end else begin
          r_stall_cnt <= r_stall_cnt + 1'b1;
        end
      end else begin
        r_stall_cnt <= '0;
      end
`endif
    end
  end
  assign locked   = r_state == LOCKED;
  assign err      = r_err;
  assign wrap     = r_wrap;
  assign err_cnt  = r_err_cnt;
  assign wrap_cnt = r_wrap_cnt;
endmodule
